// File: rtl/prio_encoder_q.sv
// Registered priority encoder with a sticky pending vector and valid/ready issue port.
// RR=0 issues the highest pending index first; RR=1 scans round-robin from a rotating pointer.
module prio_encoder_q #(
   parameter int unsigned  N  = 8,
   parameter int unsigned  RR = 0,
   localparam int unsigned W  = (N > 2) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i,
   output logic [W-1:0] y,
   output logic         valid,
   input  logic         ready,
   output logic [N-1:0] pend,
   output logic         ovf
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t       state, state_nxt;
   logic [W-1:0] ptr, ptr_nxt, y_nxt;
   logic [W-1:0] sel, sel_fix, sel_rr;
   logic [N-1:0] clr, cand, pend_nxt;
   logic         found, hit, ovf_nxt;
   int unsigned  idx;

   // The presented index leaves the candidate set in the cycle it is accepted.
   always_comb begin : cand_gen
      clr   = (valid && ready) ? (N'(1) << y) : '0;
      cand  = pend & ~clr;
      found = |cand;
   end

   // Highest set index wins.
   always_comb begin : fix_scan
      sel_fix = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (cand[W'(k)]) sel_fix = W'(k);
      end
   end

   // First set index at or after ptr; ptr <= N-1 so a single subtract wraps.
   always_comb begin : rr_scan
      sel_rr = '0;
      hit    = 1'b0;
      idx    = 0;
      for (int unsigned off = 0; off < N; off++) begin
         idx = 32'(ptr) + off;
         if (idx >= N) idx = idx - N;
         if (!hit && cand[W'(idx)]) begin
            sel_rr = W'(idx);
            hit    = 1'b1;
         end
      end
   end

   assign sel = (RR != 0) ? sel_rr : sel_fix;

   always_comb begin : next_state
      state_nxt = state;
      y_nxt     = y;
      ptr_nxt   = ptr;
      pend_nxt  = (pend & ~clr) | i;
      ovf_nxt   = |(i & pend & ~clr);
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = HOLD;
               y_nxt     = sel;
               ptr_nxt   = (sel == W'(N - 1)) ? '0 : sel + W'(1);
            end
         end
         HOLD: begin
            if (ready) begin
               if (found) begin
                  y_nxt   = sel;
                  ptr_nxt = (sel == W'(N - 1)) ? '0 : sel + W'(1);
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         y     <= '0;
         ptr   <= '0;
         pend  <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         y     <= y_nxt;
         ptr   <= ptr_nxt;
         pend  <= pend_nxt;
         ovf   <= ovf_nxt;
      end
   end

   assign valid = (state == HOLD);

endmodule

// File: tb/tb_prio_encoder_q.sv
// Directed bench for prio_encoder_q: fixed-priority N=8, round-robin N=8 and N=5.
module tb_prio_encoder_q;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [7:0] i0 = '0, pend0;
   logic [2:0] y0;
   logic       valid0, ovf0, ready0 = 1'b0;

   logic [7:0] i8 = '0, pend8;
   logic [2:0] y8;
   logic       valid8, ovf8, ready8 = 1'b0;

   logic [4:0] i5 = '0, pend5;
   logic [2:0] y5;
   logic       valid5, ovf5, ready5 = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prio_encoder_q #(.N(8), .RR(0)) dut0 (
      .clk(clk), .rst(rst), .i(i0), .y(y0), .valid(valid0),
      .ready(ready0), .pend(pend0), .ovf(ovf0));

   prio_encoder_q #(.N(8), .RR(1)) dut8 (
      .clk(clk), .rst(rst), .i(i8), .y(y8), .valid(valid8),
      .ready(ready8), .pend(pend8), .ovf(ovf8));

   prio_encoder_q #(.N(5), .RR(1)) dut5 (
      .clk(clk), .rst(rst), .i(i5), .y(y5), .valid(valid5),
      .ready(ready5), .pend(pend5), .ovf(ovf5));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; i0 = 8'hFF; ready0 = 1'b1;
      tick(); tick();
      rst = 1'b0; i0 = 8'h00;
      n_checks++;
      if (y0 !== 3'd0 || valid0 !== 1'b0 || pend0 !== 8'h00 || ovf0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: y=%0d valid=%b pend=%h ovf=%b, want 0 0 00 0", y0, valid0, pend0, ovf0);
      end
      n_checks++;
      if (valid8 !== 1'b0 || pend8 !== 8'h00 || valid5 !== 1'b0 || pend5 !== 5'h00) begin
         n_fail++;
         $display("FAIL reset_rr: v8=%b p8=%h v5=%b p5=%h, want 0", valid8, pend8, valid5, pend5);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (valid0 !== 1'b0 || pend0 !== 8'h00 || ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: valid=%b pend=%h ovf=%b, want 0 00 0", k, valid0, pend0, ovf0);
         end
      end
   endtask

   task automatic test_fixed_drain();
      logic [2:0] ey [4] = '{3'd7, 3'd5, 3'd2, 3'd2};
      logic       ev [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0] ep [4] = '{8'hA4, 8'h24, 8'h04, 8'h00};
      ready0 = 1'b1; i0 = 8'hA4;
      tick();
      i0 = 8'h00;
      n_checks++;
      if (pend0 !== 8'hA4 || valid0 !== 1'b0) begin
         n_fail++;
         $display("FAIL fixed_capture: pend=%h valid=%b, want a4 0", pend0, valid0);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if (y0 !== ey[k] || valid0 !== ev[k] || pend0 !== ep[k]) begin
            n_fail++;
            $display("FAIL fixed_drain[%0d]: y=%0d valid=%b pend=%h, want %0d %b %h",
                     k, y0, valid0, pend0, ey[k], ev[k], ep[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      ready0 = 1'b0; i0 = 8'h10;
      tick();
      i0 = 8'h00;
      tick();
      n_checks++;
      if (valid0 !== 1'b1 || y0 !== 3'd4) begin
         n_fail++;
         $display("FAIL bp_first: valid=%b y=%0d, want 1 4", valid0, y0);
      end
      i0 = 8'h80;
      tick();
      i0 = 8'h00;
      tick();
      n_checks++;
      if (valid0 !== 1'b1 || y0 !== 3'd4 || pend0 !== 8'h90) begin
         n_fail++;
         $display("FAIL bp_hold: valid=%b y=%0d pend=%h, want 1 4 90", valid0, y0, pend0);
      end
      ready0 = 1'b1;
      tick();
      n_checks++;
      if (valid0 !== 1'b1 || y0 !== 3'd7 || pend0 !== 8'h80) begin
         n_fail++;
         $display("FAIL bp_release: valid=%b y=%0d pend=%h, want 1 7 80", valid0, y0, pend0);
      end
      tick();
      n_checks++;
      if (valid0 !== 1'b0 || pend0 !== 8'h00) begin
         n_fail++;
         $display("FAIL bp_empty: valid=%b pend=%h, want 0 00", valid0, pend0);
      end
   endtask

   task automatic test_merge();
      ready0 = 1'b0; i0 = 8'h08;
      tick();
      i0 = 8'h00;
      tick();
      n_checks++;
      if (valid0 !== 1'b1 || y0 !== 3'd3 || ovf0 !== 1'b0) begin
         n_fail++;
         $display("FAIL merge_setup: valid=%b y=%0d ovf=%b, want 1 3 0", valid0, y0, ovf0);
      end
      i0 = 8'h08;
      tick();
      i0 = 8'h00;
      n_checks++;
      if (ovf0 !== 1'b1 || pend0 !== 8'h08) begin
         n_fail++;
         $display("FAIL merge_ovf: ovf=%b pend=%h, want 1 08", ovf0, pend0);
      end
      tick();
      n_checks++;
      if (ovf0 !== 1'b0) begin
         n_fail++;
         $display("FAIL merge_ovf_pulse: ovf=%b, want 0", ovf0);
      end
      ready0 = 1'b1;
      tick();
      n_checks++;
      if (valid0 !== 1'b0 || pend0 !== 8'h00) begin
         n_fail++;
         $display("FAIL merge_once: valid=%b pend=%h, want 0 00", valid0, pend0);
      end
      // Re-request on the accepting edge: no ovf, index comes back.
      ready0 = 1'b0; i0 = 8'h08;
      tick();
      i0 = 8'h00;
      tick();
      ready0 = 1'b1; i0 = 8'h08;
      tick();
      i0 = 8'h00;
      n_checks++;
      if (ovf0 !== 1'b0 || pend0 !== 8'h08 || valid0 !== 1'b0) begin
         n_fail++;
         $display("FAIL requeue_edge: ovf=%b pend=%h valid=%b, want 0 08 0", ovf0, pend0, valid0);
      end
      tick();
      n_checks++;
      if (valid0 !== 1'b1 || y0 !== 3'd3) begin
         n_fail++;
         $display("FAIL requeue_reissue: valid=%b y=%0d, want 1 3", valid0, y0);
      end
      tick();
      n_checks++;
      if (valid0 !== 1'b0 || pend0 !== 8'h00) begin
         n_fail++;
         $display("FAIL requeue_drain: valid=%b pend=%h, want 0 00", valid0, pend0);
      end
   endtask

   task automatic test_rr8();
      logic [2:0] ey [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
      ready8 = 1'b1; i8 = 8'hFF;
      tick();
      n_checks++;
      if (pend8 !== 8'hFF || valid8 !== 1'b0) begin
         n_fail++;
         $display("FAIL rr8_capture: pend=%h valid=%b, want ff 0", pend8, valid8);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if (valid8 !== 1'b1 || y8 !== ey[k]) begin
            n_fail++;
            $display("FAIL rr8_seq[%0d]: valid=%b y=%0d, want 1 %0d", k, valid8, y8, ey[k]);
         end
      end
      i8 = 8'h00;
   endtask

   task automatic test_rr5();
      logic [2:0] ey [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
      ready5 = 1'b1; i5 = 5'h1F;
      tick();
      for (int k = 0; k < 7; k++) begin
         tick();
         n_checks++;
         if (valid5 !== 1'b1 || y5 !== ey[k]) begin
            n_fail++;
            $display("FAIL rr5_seq[%0d]: valid=%b y=%0d, want 1 %0d", k, valid5, y5, ey[k]);
         end
      end
      i5 = 5'h00;
   endtask

   task automatic test_async_reset();
      ready0 = 1'b0; i0 = 8'h3C;
      tick();
      i0 = 8'h00;
      tick();
      n_checks++;
      if (valid0 !== 1'b1 || y0 !== 3'd5 || pend0 !== 8'h3C) begin
         n_fail++;
         $display("FAIL arst_setup: valid=%b y=%0d pend=%h, want 1 5 3c", valid0, y0, pend0);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (y0 !== 3'd0 || valid0 !== 1'b0 || pend0 !== 8'h00 || ovf0 !== 1'b0 || pend8 !== 8'h00) begin
         n_fail++;
         $display("FAIL arst_clear: y=%0d valid=%b pend=%h ovf=%b pend8=%h, want 0 0 00 0 00",
                  y0, valid0, pend0, ovf0, pend8);
      end
      #2 rst = 1'b0;
      ready0 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (valid0 !== 1'b0 || pend0 !== 8'h00 || ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_after[%0d]: valid=%b pend=%h ovf=%b, want 0 00 0", k, valid0, pend0, ovf0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_drain();
      test_backpressure();
      test_merge();
      test_rr8();
      test_rr5();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prio_encoder_q.md
# prio_encoder_q

Parametrised, registered priority encoder with request queuing; the sequential successor to the team's fixed 8-to-3 OR-encoder. It captures one-cycle request pulses on N lines into a sticky pending vector and issues their binary indices one at a time over a valid/ready handshake. Fixed-priority mode uses highest-index-wins, the same bit weighting as the combinational encoder. Round-robin mode gives fair service. It sits between interrupt/event sources and a single consumer that must see every event index exactly once.

## Interface
- N, default 8: number of request lines; N >= 2.
- RR, default 0: 0 = fixed priority, highest index wins; 1 = round-robin.
- W, derived (not overridable): max(1, clog2(N)), index width.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- i  in  N  request pulses; bit k high for a cycle means event k occurred.
- y  out  W  index of the issued event; valid only while valid = 1.
- valid  out  1  y holds an unaccepted event.
- ready  in  1  consumer accepts y when valid && ready at a rising edge.
- pend  out  N  pending vector; includes the bit currently presented on y.
- ovf  out  1  one-cycle pulse: a request merged into an already-pending bit.

## Operation
- Pending update each edge: pend <= (pend & ~clr) | i. clr is onehot(y) when valid && ready, else 0. Set wins over clear on the same bit.
- Selection candidate set: cand = pend & ~clr. Only registered pend is used; same-cycle i is never selected directly.
- Load condition: (!valid || ready).
  - If the load condition holds and cand != 0: y <= selected index, valid <= 1.
  - If the load condition holds and cand == 0: valid <= 0, y holds its last value.
  - If the load condition is false: y and valid hold, and y is stable under backpressure.
- Fixed mode (RR=0): select the highest set index of cand.
- Round-robin mode (RR=1): keep pointer ptr (W bits, reset 0).
  - Select the first set bit of cand scanning ascending from ptr, wrapping N-1 -> 0.
  - On every load, ptr <= (selected + 1) mod N.
  - For non-power-of-2 N, ptr never exceeds N-1.
- Overflow: ovf <= |(i & pend & ~clr). The event is merged, not queued twice, and ovf asserts in the cycle after the merge edge.
- States:
  - IDLE (valid=0): goes to HOLD on the first edge where pend != 0.
  - HOLD (valid=1): accept with cand != 0 stays in HOLD with a new y. Accept with cand == 0 goes to IDLE. No accept stays in HOLD, frozen.
- The event in y stays in pend until accepted. It is never lost or duplicated except by documented merge.

## Timing
- Reset values: y=0, valid=0, pend=0, ovf=0, ptr=0. Assertion clears these asynchronously. The first edge after deassertion behaves like a normal IDLE edge.
- Reset mid-operation drops all pending and in-flight events without an ovf pulse.
- Latency:
  - i[k] at edge E0 sets pend[k] after E0.
  - valid=1, y=k after E1, if k wins selection.
- Throughput: one event per cycle while ready=1 and cand != 0.
- Simultaneous i[k] and acceptance of k re-queues k: pend[k] stays 1 and ovf=0. In fixed mode k is reissued on the next load if it is still highest.
- i bits outside 0..N-1 do not exist. All index arithmetic is modulo N, W bits wide.

## Test plan
- Reset: drive rst=1 with i=0xFF, then release with i=0 -> y=0, valid=0, pend=0, ovf=0. Nothing issues afterward.
- Fixed mode, N=8, ready=1: pulse i=0xA4 for one cycle -> pend=0xA4, then y=7, 5, 2 on three consecutive edges. pend goes 0xA4 -> 0x24 -> 0x04 -> 0x00, and valid drops on the fourth edge.
- Backpressure, fixed mode, ready=0: pulse i=0x10 -> valid=1, y=4. Later pulse i=0x80 -> y stays 4 and pend=0x90. Raise ready -> y=7 next, then valid=0.
- Merge: with pend[3]=1 unaccepted and ready=0, pulse i[3] -> ovf=1 for exactly one cycle. With ready=1 afterwards, index 3 issues exactly once. Pulse i[3] on the accepting edge -> ovf=0 and index 3 reissues.
- Round-robin, RR=1, N=8: hold i=0xFF and ready=1 -> y=0,1,...,7,0,1 with valid continuously 1. Repeat with N=5 -> y=0,1,2,3,4,0 and ptr never exceeds 4.
- Async reset mid-run: assert rst between edges while valid=1 and pend=0x3C -> outputs clear before the next edge. No stale index issues after release.
